mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between the instruction-fetch requester (IF state) and the data requester (LDUR/STUR in EX states) of the multicycle ARM64 core.
- Arbitrates between the two requesters with bounded starvation.
- Sequences a variable-latency memory handshake and returns read data and acknowledge to the winning requester.
- Aborts hung transactions with an error after a timeout.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- STARVE_MAX, 3, consecutive data grants allowed while IF waits; legal range >=1.
- TIMEOUT, 255, cycles in WAIT without mem_ready before abort; legal range >=1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, level, held until if_ack/if_err.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch data, valid while if_ack=1.
- if_ack  out  1  one-cycle fetch completion pulse.
- if_err  out  1  one-cycle fetch timeout pulse.
- d_req  in  1  data request, level, held until d_ack/d_err.
- d_we  in  1  1=store, 0=load.
- d_size  in  2  access size code, passed through.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, valid while d_ack=1.
- d_ack  out  1  one-cycle data completion pulse.
- d_err  out  1  one-cycle data timeout pulse.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable.
- mem_size  out  2  memory access size.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion, sampled on edges where mem_req=1.
- busy  out  1  1 whenever state != IDLE.
- owner  out  1  0=IF, 1=data; current/last grant.

Behaviour:
- Reset: clock is the only clock. reset is asynchronous, active-low. While reset=0:
  - state=IDLE.
  - All outputs 0, including mem_req, acks, errs, rdata buses, owner, busy.
  - Starvation counter and timeout counter = 0.
  - Asserting reset mid-transaction drops mem_req immediately without waiting for a clock edge. No ack or err is issued for the aborted transaction.
- States: IDLE, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant data, unless starve_cnt >= STARVE_MAX, in which case grant IF.
  - On grant, the same edge latches we/size/addr/wdata into mem_* registers (IF grant forces we=0, size=2'b11), sets owner, and moves to WAIT.
- WAIT:
  - mem_req=1.
  - mem_* registers are frozen; requester input changes are ignored.
  - Edge with mem_ready=1: capture mem_rdata into the owner's rdata register, set that ack for the next cycle, go to DONE.
  - Timeout: tmo_cnt increments on each WAIT edge without ready. Edge where tmo_cnt == TIMEOUT-1 without ready: set owner's err, go to DONE, rdata unchanged.
  - mem_ready arriving on the timeout edge wins; ack is issued, not err.
- DONE:
  - mem_req=0.
  - Exactly one of ack/err is high for this single cycle.
  - Requests are ignored here; the requester must drop req by the end of DONE.
  - Next state is always IDLE, giving a one-cycle bus turnaround.
- Starvation counter (saturating at STARVE_MAX):
  - Increments on each data grant made while if_req=1.
  - Clears on any IF grant.
  - Unchanged by data grants with if_req=0.
- Latency: request seen at edge k in IDLE, with mem_ready high in the first WAIT cycle, gives ack high in cycle k+2 and IDLE again at edge k+3. Back-to-back throughput is one transaction per 3 cycles minimum.
- Holding: mem_rdata, if_rdata and d_rdata hold their last captured value after ack. Only the ack qualifies the data.
- Loads vs stores: stores still complete via mem_ready/d_ack. d_rdata is captured for stores but is don't-care to the requester.
- Requester protocol violations (req dropped during WAIT) do not cancel the memory access. The ack is still issued.

Test Plan:
- Single fetch:
  - Stimulus: if_req=1, if_addr=0x1000; memory returns 0xD503201F with ready in the 1st WAIT cycle.
  - Response: mem_req=1 with mem_addr=0x1000 and mem_we=0 for exactly 1 cycle; if_ack=1 in the following cycle with if_rdata=0xD503201F; busy low again 3 cycles after the request.
- Store with wait states:
  - Stimulus: d_req=1, d_we=1, d_addr=0x2008, d_wdata=0xCAFE; mem_ready after 4 WAIT cycles.
  - Response: mem_req high for 4 cycles with stable mem_wdata=0xCAFE; then d_ack pulse; if_ack stays 0.
- Contention and starvation bound (STARVE_MAX=3):
  - Stimulus: if_req and d_req held high continuously; each requester re-asserts after its ack.
  - Response: grant sequence D, D, D, IF, D, D, D, IF; owner matches this sequence.
- Timeout (TIMEOUT=8):
  - Stimulus: d_req=1; mem_ready never asserted.
  - Response: mem_req high for exactly 8 cycles; d_err pulses once; d_ack never asserts; next request is served normally.
- Ready on timeout edge:
  - Stimulus: mem_ready asserted exactly in the 8th WAIT cycle.
  - Response: ack pulse, no err.
- Reset mid-transaction:
  - Stimulus: reset driven low asynchronously during WAIT.
  - Response: mem_req, busy and owner fall to 0 before the next clock edge; no ack/err after release; the first post-reset request completes correctly with starve_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the memory port and the arbiter.
// The slave modport is the arbiter's view; master is the requesters'/memory's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  // Instruction-fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              if_err;

  // Data (LDUR/STUR) requester
  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              d_err;

  // Shared memory port
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack, if_err,
    input  d_req, d_we, d_size, d_addr, d_wdata,
    output d_rdata, d_ack, d_err,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack, if_err,
    output d_req, d_we, d_size, d_addr, d_wdata,
    input  d_rdata, d_ack, d_err,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the multicycle core: fetch vs. data requester,
// bounded starvation of fetch, variable-latency handshake with timeout abort.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic                owner
);

  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] FETCH_SIZE = 2'b11;

  logic [1:0]        state;
  logic [SC_W-1:0]   starve_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  logic              mem_req_q;
  logic              mem_we_q;
  logic [1:0]        mem_size_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_ack_q;
  logic              if_err_q;
  logic              d_ack_q;
  logic              d_err_q;
  logic              owner_q;

  logic              grant_valid;
  logic              grant_data;
  logic              tmo_hit;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_data  = 1'b0;
    if (state == IDLE) begin
      if (bus.d_req && (!bus.if_req || (starve_cnt < SC_W'(STARVE_MAX)))) begin
        grant_valid = 1'b1;
        grant_data  = 1'b1;
      end else if (bus.if_req) begin
        grant_valid = 1'b1;
      end
    end
  end

  // Last WAIT edge before abort; mem_ready on this same edge still wins.
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // NOTE: state registers use non-blocking assignments so every register in
  // the block samples pre-edge values, matching the flop hardware.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      tmo_cnt     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      owner_q     <= 1'b0;
    end else begin
      // Completion strobes are single-cycle pulses.
      if_ack_q <= 1'b0;
      if_err_q <= 1'b0;
      d_ack_q  <= 1'b0;
      d_err_q  <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_valid) begin
            state     <= WAIT;
            mem_req_q <= 1'b1;
            owner_q   <= grant_data;
            tmo_cnt   <= '0;
            if (grant_data) begin
              mem_we_q    <= bus.d_we;
              mem_size_q  <= bus.d_size;
              mem_addr_q  <= bus.d_addr;
              mem_wdata_q <= bus.d_wdata;
              if (bus.if_req && (starve_cnt < SC_W'(STARVE_MAX)))
                starve_cnt <= starve_cnt + SC_W'(1);
            end else begin
              mem_we_q    <= 1'b0;
              mem_size_q  <= FETCH_SIZE;
              mem_addr_q  <= bus.if_addr;
              mem_wdata_q <= '0;
              starve_cnt  <= '0;
            end
          end
        end

        WAIT: begin
          if (bus.mem_ready) begin
            state     <= DONE;
            mem_req_q <= 1'b0;
            if (owner_q) begin
              d_rdata_q <= bus.mem_rdata;
              d_ack_q   <= 1'b1;
            end else begin
              if_rdata_q <= bus.mem_rdata;
              if_ack_q   <= 1'b1;
            end
          end else if (tmo_hit) begin
            state     <= DONE;
            mem_req_q <= 1'b0;
            if (owner_q) d_err_q  <= 1'b1;
            else         if_err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        // Turnaround cycle: the requester drops its request while ack/err is visible.
        DONE: begin
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_size  = mem_size_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_err    = if_err_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_err     = d_err_q;

  assign busy  = (state != IDLE);
  assign owner = owner_q;

endmodule
